// File: rtl/gate3_resp_checker.sv
// Response checker for an OR3/NOR3 pair: checks each sample, tracks the 8 input combos, reports pass/fail.
// Latency: results visible one cycle after the sample; optional dup_count under GATE3_CHK_DUPCOUNT_EN.
// Backpressure: none; one sample per in_valid cycle is always accepted while in RUN.
module gate3_resp_checker #(
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [2:0]       in_abc,
    input  logic             in_or,
    input  logic             in_nor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       coverage,
    output logic [2:0]       first_err_abc,
`ifdef GATE3_CHK_DUPCOUNT_EN
    output logic [7:0]       dup_count,
`endif
    output logic             first_err_vld
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = 1;
    localparam logic [15:0]      TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] idle_cnt;
    logic        exp_or;
    logic        mismatch;
    logic [7:0]  cov_next;

    always_comb begin
        exp_or   = (in_abc != 3'd0);
        mismatch = (in_or != exp_or) | (in_nor != ~exp_or);
        cov_next = coverage | (8'd1 << in_abc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            coverage      <= 8'd0;
            first_err_abc <= 3'd0;
            first_err_vld <= 1'b0;
            idle_cnt      <= 16'd0;
`ifdef GATE3_CHK_DUPCOUNT_EN
            dup_count     <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        coverage      <= 8'd0;
                        first_err_abc <= 3'd0;
                        first_err_vld <= 1'b0;
                        idle_cnt      <= 16'd0;
`ifdef GATE3_CHK_DUPCOUNT_EN
                        dup_count     <= 8'd0;
`endif
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        idle_cnt <= 16'd0;
                        coverage <= cov_next;
                        if (mismatch) begin
                            if (err_count != ERR_MAX)
                                err_count <= err_count + ERR_ONE;
                            if (!first_err_vld) begin
                                first_err_abc <= in_abc;
                                first_err_vld <= 1'b1;
                            end
                        end
`ifdef GATE3_CHK_DUPCOUNT_EN
                        if (coverage[in_abc] && dup_count != 8'hFF)
                            dup_count <= dup_count + 8'd1;
`endif
                        // err_count is sticky non-zero, so it plus this sample's mismatch covers the whole run
                        if (cov_next == 8'hFF) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mismatch;
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate3_resp_checker.sv
// Directed bench for gate3_resp_checker: a reference model pushes expected output snapshots
// to a queue as each cycle's stimulus is driven; they are popped and compared after the edge.
module tb_gate3_resp_checker;

    localparam int TIMEOUT = 64;

    logic       clk;
    logic       rst, start, in_valid, in_or, in_nor;
    logic [2:0] in_abc;
    logic       busy, done, pass, first_err_vld;
    logic [7:0] err_count, coverage;
    logic [2:0] first_err_abc;
`ifdef GATE3_CHK_DUPCOUNT_EN
    logic [7:0] dup_count;
`endif

    int checks   = 0;
    int failures = 0;

    gate3_resp_checker #(.ERR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_abc        (in_abc),
        .in_or         (in_or),
        .in_nor        (in_nor),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .coverage      (coverage),
        .first_err_abc (first_err_abc),
`ifdef GATE3_CHK_DUPCOUNT_EN
        .dup_count     (dup_count),
`endif
        .first_err_vld (first_err_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic [7:0] cov;
        logic [2:0] fabc;
        logic       fvld;
        logic [7:0] dup;
    } snap_t;

    snap_t exp_q[$];

    // reference model state: 0=IDLE 1=RUN 2=DONE
    int    m_state = 0;
    int    m_idle  = 0;
    snap_t m;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m      = '0;
        m_idle = 0;
    endtask

    task automatic model_step(input logic r, s, v, input logic [2:0] abc, input logic o, n);
        logic good_or, bad;
        logic [7:0] bit_i;
        if (r) begin
            model_clear();
            m_state = 0;
        end else if (m_state == 0 || m_state == 2) begin
            if (s) begin
                model_clear();
                m_state = 1;
                m.busy  = 1'b1;
            end
        end else if (v) begin
            good_or = |abc;
            bad     = (o !== good_or) || (n !== !good_or);
            bit_i   = 8'd0;
            bit_i[abc] = 1'b1;
            m_idle  = 0;
            if ((m.cov & bit_i) != 8'd0 && m.dup != 8'hFF) m.dup = m.dup + 8'd1;
            if (bad) begin
                if (m.err != 8'hFF) m.err = m.err + 8'd1;
                if (!m.fvld) begin
                    m.fvld = 1'b1;
                    m.fabc = abc;
                end
            end
            m.cov = m.cov | bit_i;
            if (m.cov == 8'hFF) begin
                m_state = 2;
                m.busy  = 1'b0;
                m.done  = 1'b1;
                m.pass  = (m.err == 8'd0);
            end
        end else begin
            m_idle++;
            if (m_idle >= TIMEOUT) begin
                m_state = 2;
                m.busy  = 1'b0;
                m.done  = 1'b1;
                m.pass  = 1'b0;
            end
        end
    endtask

    function automatic snap_t dut_snap();
        snap_t g;
        g.busy = busy;
        g.done = done;
        g.pass = pass;
        g.err  = err_count;
        g.cov  = coverage;
        g.fabc = first_err_abc;
        g.fvld = first_err_vld;
`ifdef GATE3_CHK_DUPCOUNT_EN
        g.dup  = dup_count;
`else
        g.dup  = m.dup;
`endif
        return g;
    endfunction

    task automatic cyc(input logic r, s, v, input logic [2:0] abc, input logic o, n);
        snap_t e;
        rst = r; start = s; in_valid = v; in_abc = abc; in_or = o; in_nor = n;
        model_step(r, s, v, abc, o, n);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("snapshot", 40'(dut_snap()), 40'(e));
    endtask

    task automatic good(input logic [2:0] abc);
        cyc(1'b0, 1'b0, 1'b1, abc, |abc, ~|abc);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_abc = 3'd0; in_or = 1'b0; in_nor = 1'b0;

        // reset
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("reset_outputs", {busy, done, pass, err_count, coverage, first_err_abc, first_err_vld}, 40'd0);

        // clean run 0..7
        do_start();
        chk("start_busy", {busy, done}, 2'b10);
        for (int i = 0; i < 7; i++) good(3'(i));
        chk("not_done_at_7", done, 1'b0);
        good(3'd7);
        chk("clean_done", {done, pass, busy}, 3'b110);
        chk("clean_err", err_count, 8'd0);
        chk("clean_cov", coverage, 8'hFF);

        // abc=5 with or/nor wrong
        do_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) cyc(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
            else        good(3'(i));
        end
        chk("err5_done_pass", {done, pass}, 2'b10);
        chk("err5_count", err_count, 8'd1);
        chk("err5_first", {first_err_vld, first_err_abc}, 4'b1101);

        // double-wrong sample counts once; first error stays at abc=0
        do_start();
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
        chk("dbl_err_count", err_count, 8'd2);
        chk("dbl_first", {first_err_vld, first_err_abc}, 4'b1000);
        good(3'd1); good(3'd2); good(3'd4); good(3'd5); good(3'd6); good(3'd7);
        chk("dbl_done_pass", {done, pass}, 2'b10);

        // timeout with 7 of 8 combos, sample 2 resent twice
        do_start();
        good(3'd0); good(3'd1); good(3'd2); good(3'd2); good(3'd2);
        good(3'd3); good(3'd4); good(3'd5); good(3'd6);
        for (int i = 0; i < TIMEOUT - 1; i++) idle_cyc();
        chk("to_not_yet", {done, busy}, 2'b01);
        idle_cyc();
        chk("to_done_pass", {done, pass, busy}, 3'b100);
        chk("to_cov", coverage, 8'h7F);
`ifdef GATE3_CHK_DUPCOUNT_EN
        chk("to_dup", dup_count, 8'd2);
`endif

        // reset mid-run, then samples without start are ignored
        do_start();
        good(3'd0); good(3'd1); good(3'd2); good(3'd3);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("midrst_outputs", {busy, done, pass, err_count, coverage, first_err_abc, first_err_vld}, 40'd0);
        good(3'd4); good(3'd5);
        cyc(1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
        chk("nostart_cov", {coverage, err_count, busy}, 17'd0);

        // pass, then start in DONE with a bad sample in the same cycle
        do_start();
        for (int i = 7; i >= 0; i--) good(3'(i));
        chk("pre_restart", {done, pass}, 2'b11);
        cyc(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
        chk("restart_cleared", {busy, done, err_count, coverage}, 18'b10_0000_0000_0000_0000);
        for (int i = 0; i < 8; i++) good(3'(i));
        chk("restart_pass", {done, pass, err_count}, 10'b11_0000_0000);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate3_resp_checker.md
Name: gate3_resp_checker

Overview:
- Response-analysis end of the 3-input gate test flow: consumes the sample stream from a stimulus source and the OR3/NOR3 pair under test.
- Per valid sample {a,b,c, or_out, nor_out}: checks both outputs against expected values and tracks which of the 8 input combinations have been seen.
- Reports busy/done/pass, an error count and first-failure capture.
- Sits beside the OR3/NOR3 instances in the ALU self-check harness; synthesizable, single clock domain.

Parameters:
ERR_W, 8, width of the error counter; counter saturates at 2^ERR_W-1
TIMEOUT, 64, consecutive RUN cycles without in_valid before the run is aborted as failed; legal range 2..65535

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begins a new check run; honoured only in IDLE or DONE
in_valid  input  1  sample qualifier; one sample per cycle when high
in_abc  input  3  stimulus sample, {a,b,c}; a is MSB
in_or  input  1  observed OR3 output for in_abc
in_nor  input  1  observed NOR3 output for in_abc
busy  output  1  high while in RUN
done  output  1  high while in DONE (level, not pulse)
pass  output  1  valid when done=1; 1 = full coverage and zero errors
err_count  output  ERR_W  number of mismatching samples in current/last run
coverage  output  8  bit i set once in_abc==i has been seen in this run
first_err_abc  output  3  in_abc of first mismatching sample; 0 if none
first_err_vld  output  1  first_err_abc holds a captured value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. rst sampled high: state=IDLE, and every output is cleared to 0: busy, done, pass, err_count, coverage, first_err_abc, first_err_vld, plus the timeout counter. rst overrides start and in_valid in the same cycle, and aborts a run in progress.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle.
  - On entry to RUN: clear err_count, coverage, first_err_*, pass and timeout counter.
  - in_valid is ignored.
- RUN:
  - busy=1.
  - On in_valid=1, expected values: exp_or = in_abc!=0; exp_nor = ~exp_or.
  - Mismatch = (in_or!=exp_or) | (in_nor!=exp_nor). A sample with both outputs wrong counts once.
  - On mismatch: err_count += 1 (saturating). If first_err_vld=0, capture in_abc into first_err_abc and set first_err_vld.
  - coverage[in_abc] <= 1.
  - All updates are visible the cycle after the sample (latency 1).
  - Repeated combinations are checked again but do not change coverage.
  - start is ignored while in RUN.
- Completion:
  - If a valid sample makes (coverage | onehot(in_abc)) == 8'hFF, the next state is DONE.
  - pass is registered on the same edge as: (no error so far including this sample) & full coverage.
- Timeout:
  - The counter increments on each RUN cycle with in_valid=0 and resets to 0 on in_valid=1.
  - When it reaches TIMEOUT-1 and in_valid=0 -> DONE with pass=0. coverage and err_count hold their partial values.
- DONE:
  - done=1, busy=0. All result outputs hold.
  - in_valid is ignored.
  - start=1 -> RUN with results cleared, as from IDLE.
- Width rules: coverage index is in_abc as unsigned 0..7. err_count wraps never; it holds at max.

Optional Feature:
- Macro GATE3_CHK_DUPCOUNT_EN.
- When defined: adds output dup_count (8 bits, saturating) counting valid RUN samples whose in_abc bit was already set in coverage. Cleared on rst and on run start. Reset value 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Directed scenarios:
  - rst, start, then the 8 samples in_abc=0..7 with correct outputs (or: 0,1,1,1,1,1,1,1; nor the inverse), one per cycle -> done=1 one cycle after the 8th sample, pass=1, err_count=0, coverage=8'hFF, busy=0.
  - Same sequence but the in_abc=5 sample has in_or=0, in_nor=1 -> done=1, pass=0, err_count=1, first_err_abc=3'b101, first_err_vld=1.
  - Sample in_abc=0 with in_or=1, in_nor=1 (both wrong), then in_abc=3 with in_or=1, in_nor=1 -> err_count=2, first_err_abc=0. Then the remaining combos are sent correctly -> pass=0.
  - Only samples 0..6 sent, then in_valid=0 for 64 cycles -> done=1 exactly at timeout, pass=0, coverage=8'h7F. With GATE3_CHK_DUPCOUNT_EN, resending 2 and 2 earlier gives dup_count=2.
  - Mid-run (after 4 samples) rst=1 for one cycle -> all outputs 0, state IDLE. Samples sent without start -> coverage stays 0.
  - After a passing run, start=1 in DONE with in_valid=1 in the same cycle -> that sample ignored. The run restarts with err_count=0, coverage=0, and a fresh 8-sample sequence gives pass=1.
